// File: rtl/cnn_sched_pkg.sv
// Shared types and default constants for the CNN stage scheduler.
package cnn_sched_pkg;

    localparam int unsigned DEF_NUM_STAGES = 4;
    localparam int unsigned DEF_TIMEOUT    = 1048575;
    localparam int unsigned DEF_TMR_W      = 20;
    localparam int unsigned FRAME_CNT_W    = 16;
    localparam int unsigned PERF_CNT_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } sched_state_e;

endpackage

// File: rtl/sched_timeout_timer.sv
// WAIT-state watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT-th enabled cycle since the last clear.
module sched_timeout_timer
    import cnn_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned TMR_W   = DEF_TMR_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, count saturates at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/cnn_stage_scheduler.sv
// Frame sequencer for the CNN pipeline: issues one-hot start pulses to each
// stage in turn, waits for its ready, tracks one pending request and keeps
// sticky error flags. Optional macro CNN_SCHED_PERF_EN adds a per-frame
// cycle counter driving last_frame_cycles (constant 0 when undefined).
module cnn_stage_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned TMR_W      = DEF_TMR_W
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   frame_req,
    input  logic                   err_clr,
    input  logic [NUM_STAGES-1:0]  stage_ready,
    output logic [NUM_STAGES-1:0]  stage_start,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_timeout,
    output logic                   err_spurious,
    output logic                   err_overrun,
    output logic [PERF_CNT_W-1:0]  last_frame_cycles
);

    localparam int unsigned      IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   pending_q, pending_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   err_to_q, err_to_d;
    logic                   err_sp_q, err_sp_d;
    logic                   err_ov_q, err_ov_d;

    logic [NUM_STAGES-1:0]  idx_onehot;
    logic                   ready_hit;
    logic                   spurious_evt;
    logic                   overrun_evt;
    logic                   timeout_evt;
    logic                   tmr_clear;
    logic                   tmr_en;
    logic                   tmr_expired;

    sched_timeout_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_timer (
        .clk_i     (clk_in),
        .rst_ni    (rst_n),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_en),
        .expired_o (tmr_expired)
    );

    // Decode the current stage index and classify incoming ready pulses.
    always_comb begin
        idx_onehot        = '0;
        idx_onehot[idx_q] = 1'b1;
        ready_hit         = (state_q == ST_WAIT) && stage_ready[idx_q];
        spurious_evt      = (state_q == ST_WAIT) ? |(stage_ready & ~idx_onehot)
                                                 : |stage_ready;
    end

    // Next-state, stage index, pending request and error events.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        fcnt_d      = fcnt_q;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;
        overrun_evt = 1'b0;
        timeout_evt = 1'b0;

        if ((state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DONE)) begin
            if (frame_req) begin
                if (pending_q) begin
                    overrun_evt = 1'b1;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_req) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                end
            end
            ST_ISSUE: begin
                tmr_clear = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                // A ready that lands on the expiry cycle still advances.
                if (ready_hit) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
                    end else begin
                        state_d = ST_ISSUE;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (tmr_expired) begin
                    state_d     = ST_ERR;
                    timeout_evt = 1'b1;
                end
            end
            ST_DONE: begin
                // A request arriving here either starts the next frame or,
                // if one was already pending, is dropped as an overrun.
                pending_d = 1'b0;
                if (pending_q || frame_req) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sticky flags: err_clr wins over a same-cycle set.
    always_comb begin
        err_to_d = err_clr ? 1'b0 : (err_to_q | timeout_evt);
        err_sp_d = err_clr ? 1'b0 : (err_sp_q | spurious_evt);
        err_ov_d = err_clr ? 1'b0 : (err_ov_q | overrun_evt);
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            fcnt_q    <= '0;
            err_to_q  <= 1'b0;
            err_sp_q  <= 1'b0;
            err_ov_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            fcnt_q    <= fcnt_d;
            err_to_q  <= err_to_d;
            err_sp_q  <= err_sp_d;
            err_ov_q  <= err_ov_d;
        end
    end

    assign stage_start  = (state_q == ST_ISSUE) ? idx_onehot : '0;
    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = (state_q == ST_DONE);
    assign frame_cnt    = fcnt_q;
    assign err_timeout  = err_to_q;
    assign err_spurious = err_sp_q;
    assign err_overrun  = err_ov_q;

`ifdef CNN_SCHED_PERF_EN
    logic [PERF_CNT_W-1:0] perf_q, perf_d;
    logic [PERF_CNT_W-1:0] last_q, last_d;

    // Frame cycle counter: starts at 1 on the first ISSUE, saturates, and
    // is captured while in DONE so the first ISSUE and DONE both count.
    always_comb begin
        perf_d = perf_q;
        last_d = last_q;
        if ((state_d == ST_ISSUE) && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            perf_d = PERF_CNT_W'(1);
        end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
            if (perf_q != '1) begin
                perf_d = perf_q + PERF_CNT_W'(1);
            end
        end
        if (state_q == ST_DONE) begin
            last_d = perf_q;
        end
    end

    // Performance registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            perf_q <= '0;
            last_q <= '0;
        end else begin
            perf_q <= perf_d;
            last_q <= last_d;
        end
    end

    assign last_frame_cycles = last_q;
`else
    assign last_frame_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_stage_scheduler.sv
// Scoreboard bench for cnn_stage_scheduler: expected start/done events are
// queued when a request is driven and matched as the DUT emits them.
module tb_cnn_stage_scheduler;

    localparam int NS = 4;
    localparam int TO = 16;
`ifdef CNN_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          frame_req;
    logic          err_clr;
    logic [NS-1:0] stage_ready = '0;
    logic [NS-1:0] stage_start;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic          err_timeout;
    logic          err_spurious;
    logic          err_overrun;
    logic [31:0]   last_frame_cycles;

    cnn_stage_scheduler #(
        .NUM_STAGES (NS),
        .TIMEOUT    (TO),
        .TMR_W      (20)
    ) dut (
        .clk_in            (clk_in),
        .rst_n             (rst_n),
        .frame_req         (frame_req),
        .err_clr           (err_clr),
        .stage_ready       (stage_ready),
        .stage_start       (stage_start),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_cnt         (frame_cnt),
        .err_timeout       (err_timeout),
        .err_spurious      (err_spurious),
        .err_overrun       (err_overrun),
        .last_frame_cycles (last_frame_cycles)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    endtask

    typedef struct { int at; logic [NS-1:0] val; } start_exp_t;
    typedef struct { int at; logic [15:0] cnt; } done_exp_t;
    start_exp_t sq[$];
    done_exp_t  dq[$];

    // Bench model of the request/pending behaviour.
    int busy_until = -1;
    int last_base  = -100;
    int dly        = 10;
    int fcnt_m     = 0;

    // Responder controls.
    logic [NS-1:0] mute = '0;
    int spur_at  = -1;
    int spur_idx = 0;
    int ready_at[NS];

    function automatic int perf_exp(input int v);
        return PERF ? v : 0;
    endfunction

    task automatic push_frame(input int t, input int nst, input bit has_done);
        int base;
        int len;
        start_exp_t s;
        done_exp_t  d;
        len = (dly + 1) * NS + 1;
        if (t >= busy_until) begin
            base = t;
        end else if (last_base >= t) begin
            return;
        end else begin
            base = busy_until;
        end
        for (int k = 0; k < nst; k++) begin
            s.at  = base + 1 + (dly + 1) * k;
            s.val = NS'(1 << k);
            sq.push_back(s);
        end
        if (has_done) begin
            fcnt_m++;
            d.at  = base + len;
            d.cnt = 16'(fcnt_m);
            dq.push_back(d);
        end
        busy_until = base + len;
        last_base  = base;
    endtask

    task automatic req(input int nst, input bit has_done);
        frame_req = 1'b1;
        push_frame(cyc, nst, has_done);
        @(negedge clk_in);
        frame_req = 1'b0;
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk_in);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk_in);
        err_clr = 1'b0;
    endtask

    // Stage model: answer each start with a ready pulse dly cycles later.
    always @(negedge clk_in) begin
        for (int i = 0; i < NS; i++) begin
            if (rst_n !== 1'b1) ready_at[i] = -1;
            else if (stage_start[i]) ready_at[i] = cyc + dly;
        end
        for (int i = 0; i < NS; i++) begin
            stage_ready[i] = (rst_n === 1'b1) && !mute[i] && (ready_at[i] == cyc);
        end
        if (spur_at == cyc) stage_ready[spur_idx] = 1'b1;
    end

    // Scoreboard: match emitted starts and frame completions.
    always @(negedge clk_in) begin
        start_exp_t s;
        done_exp_t  d;
        if (stage_start != '0) begin
            if (sq.size() == 0) begin
                check("start_unexpected", 32'(stage_start), 32'd0);
            end else begin
                s = sq.pop_front();
                check("start_val", 32'(stage_start), 32'(s.val));
                check("start_cyc", cyc, s.at);
            end
        end
        if (frame_done) begin
            if (dq.size() == 0) begin
                check("done_unexpected", 32'(frame_done), 32'd0);
            end else begin
                d = dq.pop_front();
                check("done_cyc", cyc, d.at);
                check("done_cnt", 32'(frame_cnt), 32'(d.cnt));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run exceeded time limit (cyc %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        frame_req = 1'b0;
        err_clr   = 1'b0;

        // Reset state.
        to_cyc(2);
        check("rst_start", 32'(stage_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_flags", 32'({err_timeout, err_spurious, err_overrun}), 32'd0);
        check("rst_last", last_frame_cycles, 32'd0);
        rst_n = 1'b1;
        to_cyc(3);
        check("post_rst_start", 32'(stage_start), 32'd0);

        // Normal frame.
        to_cyc(5);
        req(NS, 1'b1);
        to_cyc(51);
        check("s1_busy", 32'(busy), 32'd0);
        check("s1_cnt", 32'(frame_cnt), 32'd1);
        check("s1_flags", 32'({err_timeout, err_spurious, err_overrun}), 32'd0);
        check("s1_last", last_frame_cycles, 32'(perf_exp(45)));

        // Back-to-back with pending, then overrun.
        to_cyc(60);
        req(NS, 1'b1);
        to_cyc(80);
        req(NS, 1'b1);
        check("s2_no_ovr", 32'(err_overrun), 32'd0);
        to_cyc(90);
        req(NS, 1'b1);
        to_cyc(92);
        check("s2_ovr", 32'(err_overrun), 32'd1);
        check("s2_busy", 32'(busy), 32'd1);
        to_cyc(151);
        check("s2_idle", 32'(busy), 32'd0);
        check("s2_cnt", 32'(frame_cnt), 32'(fcnt_m));
        check("s2_last", last_frame_cycles, 32'(perf_exp(45)));
        to_cyc(155);
        pulse_clr();
        to_cyc(157);
        check("s2_clr", 32'({err_timeout, err_spurious, err_overrun}), 32'd0);

        // Spurious ready on stage 3 while waiting on stage 1.
        to_cyc(160);
        spur_idx = 3;
        spur_at  = 175;
        req(NS, 1'b1);
        to_cyc(175);
        check("s3_pre", 32'(err_spurious), 32'd0);
        to_cyc(177);
        check("s3_spur", 32'(err_spurious), 32'd1);
        check("s3_busy", 32'(busy), 32'd1);
        to_cyc(206);
        check("s3_idle", 32'(busy), 32'd0);
        check("s3_cnt", 32'(frame_cnt), 32'(fcnt_m));

        // Timeout on stage 2.
        to_cyc(210);
        pulse_clr();
        to_cyc(215);
        mute = 4'b0100;
        req(3, 1'b0);
        to_cyc(254);
        check("s4_pre_to", 32'(err_timeout), 32'd0);
        to_cyc(255);
        check("s4_to", 32'(err_timeout), 32'd1);
        check("s4_busy", 32'(busy), 32'd1);
        check("s4_start", 32'(stage_start), 32'd0);
        to_cyc(260);
        frame_req = 1'b1;
        @(negedge clk_in);
        frame_req = 1'b0;
        to_cyc(263);
        check("s4_err_hold", 32'(busy), 32'd1);
        check("s4_req_ignored", 32'(err_overrun), 32'd0);
        to_cyc(265);
        pulse_clr();
        check("s4_idle", 32'(busy), 32'd0);
        check("s4_flags", 32'({err_timeout, err_spurious, err_overrun}), 32'd0);
        mute       = '0;
        busy_until = -1;
        last_base  = -100;

        // Reset mid-frame while waiting on stage 2.
        to_cyc(280);
        req(3, 1'b0);
        to_cyc(310);
        rst_n = 1'b0;
        to_cyc(311);
        check("s5_start", 32'(stage_start), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_done", 32'(frame_done), 32'd0);
        check("s5_cnt", 32'(frame_cnt), 32'd0);
        check("s5_flags", 32'({err_timeout, err_spurious, err_overrun}), 32'd0);
        check("s5_last", last_frame_cycles, 32'd0);
        to_cyc(312);
        rst_n      = 1'b1;
        fcnt_m     = 0;
        busy_until = -1;
        last_base  = -100;
        to_cyc(313);
        check("s5_no_start", 32'(stage_start), 32'd0);
        to_cyc(320);
        req(NS, 1'b1);
        to_cyc(366);
        check("s5_cnt_after", 32'(frame_cnt), 32'd1);
        check("s5_last_after", last_frame_cycles, 32'(perf_exp(45)));
        check("s5_flags_after", 32'({err_timeout, err_spurious, err_overrun}), 32'd0);

        // Ready on the exact expiry cycle wins over the timeout.
        to_cyc(370);
        dly = TO;
        req(NS, 1'b1);
        to_cyc(440);
        check("s6_no_to", 32'(err_timeout), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_cnt", 32'(frame_cnt), 32'd2);
        check("s6_last", last_frame_cycles, 32'(perf_exp(69)));
        dly = 10;

        to_cyc(445);
        check("sq_empty", 32'(sq.size()), 32'd0);
        check("dq_empty", 32'(dq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
